muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide controller in the EX stage, beside the single-cycle ALU.
//  Accepts one M-type op, runs a radix-2 shift-add or shift-subtract loop for XLEN cycles,
//  and returns one result.
//  Holds stall high so the hazard unit freezes IF/ID/EX while it runs.
// PARAMETERS
//  XLEN   32   operand/result width; must be >= 4 and even
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     async, active-low; low forces IDLE
//  start         in   1     request valid; accepted only when ready=1
//  op            in   3     funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; others -> result 0
//  a             in   XLEN  rs1 operand (dividend / multiplicand)
//  b             in   XLEN  rs2 operand (divisor / multiplier)
//  flush         in   1     squash in-flight op (branch mispredict/exception)
//  ready         out  1     1 in IDLE only
//  stall         out  1     1 while BUSY or start accepted this cycle
//  result        out  XLEN  valid when result_valid=1, held until next accept
//  result_valid  out  1     single-cycle pulse in DONE
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, stall=0, result=0, result_valid=0, counter=0.
//  FSM: IDLE -(start & ready & !flush)-> BUSY -(count==XLEN-1)-> DONE -> IDLE.
//       Any state -(flush)-> IDLE next edge; result_valid suppressed, result unchanged.
//  Accept: latch op, |a|,|b| (signed ops), sign flags, count=0.
//  BUSY per cycle:
//   - MUL: if mplier[0], acc += mcand; mcand<<=1; mplier>>=1.
//   - DIV/REM: rem={rem,quo[XLEN-1]}; if rem>=divisor, subtract and set quo bit.
//  Latency: accept at cycle 0 -> result_valid at cycle XLEN+1 (33 for XLEN=32).
//  Arithmetic: MUL returns low XLEN bits of product (signedness irrelevant).
//   - Quotient sign = sa^sb; remainder sign = sa; negation applied in DONE.
//  Boundary cases (exact RISC-V results):
//   - b==0: quotient = all-ones, remainder = a.
//   - DIV/REM with a==INT_MIN, b==-1: quotient = INT_MIN, remainder = 0.
//   - Without the fast feature, these still take XLEN+1 cycles; result forced in DONE.
//  Simultaneous events:
//   - start in BUSY/DONE is ignored; requester must hold start until ready.
//   - flush & start same cycle: flush wins, nothing accepted.
//   - reset low mid-op: immediate IDLE, no result_valid.
//  stall = (state==BUSY) | (state==IDLE & start & !flush); combinational.
// CONFIGURATION
//  MULDIV_FAST_SPECIAL_EN defined:
//   - b==0, signed overflow and b==1 skip BUSY (accept -> DONE).
//   - result_valid at cycle 1; stall high only in the accept cycle.
//  Undefined: all ops take full XLEN+1 cycles; results identical.
// STRUCTURE
//  riscv_pkg holds:
//   - XLEN_DEFAULT
//   - mdu_op_e enum (MDU_MUL=3'b000, MDU_DIV=3'b100, MDU_DIVU=3'b101, MDU_REM=3'b110, MDU_REMU=3'b111)
//   - mdu_state_e enum (IDLE, BUSY, DONE)
//  One module; no sub-module. Loop datapath (acc/rem, quo/mplier, operand regs) is inline with the FSM.
// TESTING
//  1 MUL a=7, b=6 -> result=42, result_valid at cycle 33, stall high cycles 0..32.
//  2 DIV a=-20, b=3 -> quotient -6 (0xFFFFFFFA); REM a=-20, b=3 -> result -2 (0xFFFFFFFE).
//  3 DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
//    With MULDIV_FAST_SPECIAL_EN, result_valid at cycle 1.
//  4 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5 flush at cycle 10 of a DIVU:
//    - ready=1 at cycle 11, no result_valid, result keeps previous value.
//    - next op accepted and correct.
//  6 reset low mid-BUSY -> outputs at reset values immediately; start during BUSY is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types: default width, funct3 op codes,
// sequencer states and small op-decoding helpers.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MDU_MUL  = 3'b000,
    MDU_DIV  = 3'b100,
    MDU_DIVU = 3'b101,
    MDU_REM  = 3'b110,
    MDU_REMU = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_e;

  // Every funct3 with bit 2 set is a divide/remainder op.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // DIV and REM treat operands as two's complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply / restoring shift-subtract divide, one bit per
// cycle for XLEN cycles, with stall held high while the loop runs.
// Optional feature macro: MULDIV_FAST_SPECIAL_EN -- divide by zero, signed
// overflow and divide by one go straight from accept to DONE.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int               CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       op_reg;
  logic [XLEN-1:0]  acc_reg;     // product accumulator / partial remainder
  logic [XLEN-1:0]  quo_reg;     // multiplier / dividend shifting into quotient
  logic [XLEN-1:0]  opnd_reg;    // multiplicand / divisor magnitude
  logic [XLEN-1:0]  result_reg;
  logic             sa_reg, sb_reg, divzero_reg, ovf_reg;

  logic             accept, skip;
  logic             a_neg, b_neg, in_divzero, in_ovf;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic [XLEN:0]    rem_shift;
  logic             rem_ge;
  logic [XLEN-1:0]  rem_diff;
  logic [XLEN-1:0]  quotient, remainder, final_result;

  assign accept     = (state_reg == IDLE) & start & ~flush;
  assign a_neg      = op_is_signed(op) & a[XLEN-1];
  assign b_neg      = op_is_signed(op) & b[XLEN-1];
  assign abs_a      = a_neg ? -a : a;
  assign abs_b      = b_neg ? -b : b;
  assign in_divzero = (b == '0);
  assign in_ovf     = op_is_signed(op) & (a == INT_MIN) & (b == '1);

`ifdef MULDIV_FAST_SPECIAL_EN
  assign skip = op_is_div(op) & (in_divzero | in_ovf | (b == XLEN'(1)));
`else
  assign skip = 1'b0;
`endif

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder never exceeds XLEN bits, so the low-bit difference is exact.
  assign rem_shift = {acc_reg, quo_reg[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, opnd_reg});
  assign rem_diff  = rem_shift[XLEN-1:0] - opnd_reg;

  // Sign fix-up and RISC-V boundary results, applied while in DONE.
  // For a zero divisor the loop leaves |a| in the remainder, so only the
  // quotient needs forcing; overflow forces both for clarity.
  always_comb begin
    quotient  = (sa_reg ^ sb_reg) ? -quo_reg : quo_reg;
    remainder = sa_reg ? -acc_reg : acc_reg;
    if (divzero_reg) begin
      quotient = '1;
    end
    if (ovf_reg) begin
      quotient  = INT_MIN;
      remainder = '0;
    end
    if (op_is_div(op_reg)) begin
      final_result = op_is_rem(op_reg) ? remainder : quotient;
    end else if (op_reg == MDU_MUL) begin
      final_result = acc_reg;
    end else begin
      final_result = '0;
    end
  end

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    state_next   = state_reg;
    ready        = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    result       = result_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = skip ? DONE : BUSY;
        BUSY:    if (count_reg == CNT_LAST) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    ready        = (state_reg == IDLE);
    stall        = (state_reg == BUSY) | accept;
    result_valid = (state_reg == DONE) & ~flush;
    if (result_valid) begin
      result = final_result;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture on accept, one loop iteration per BUSY cycle, result hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= '0;
      op_reg      <= '0;
      acc_reg     <= '0;
      quo_reg     <= '0;
      opnd_reg    <= '0;
      result_reg  <= '0;
      sa_reg      <= 1'b0;
      sb_reg      <= 1'b0;
      divzero_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      if (accept) begin
        count_reg   <= '0;
        op_reg      <= op;
        sa_reg      <= a_neg;
        sb_reg      <= b_neg;
        divzero_reg <= op_is_div(op) & in_divzero;
        ovf_reg     <= in_ovf;
        acc_reg     <= '0;
        if (op_is_div(op)) begin
          quo_reg  <= abs_a;
          opnd_reg <= abs_b;
        end else begin
          quo_reg  <= b;
          opnd_reg <= a;
        end
`ifdef MULDIV_FAST_SPECIAL_EN
        // Zero divisor skips the loop, so preload what it would have left behind.
        if (op_is_div(op) & in_divzero) begin
          acc_reg <= abs_a;
        end
`endif
      end else if (state_reg == BUSY) begin
        count_reg <= count_reg + CNT_W'(1);
        if (op_is_div(op_reg)) begin
          quo_reg <= {quo_reg[XLEN-2:0], rem_ge};
          acc_reg <= rem_ge ? rem_diff : rem_shift[XLEN-1:0];
        end else begin
          if (quo_reg[0]) begin
            acc_reg <= acc_reg + opnd_reg;
          end
          opnd_reg <= opnd_reg << 1;
          quo_reg  <= quo_reg >> 1;
        end
      end
      if (result_valid) begin
        result_reg <= final_result;
      end
    end
  end

endmodule
